// File: rtl/motor_duty_sequencer.sv
// Slew-limited motor duty sequencer: steps duty toward the throttle target once per PWM period,
// with brake override and a throttle-silence watchdog that ramps the motor down.
module motor_duty_sequencer #(
  parameter int unsigned TickDiv   = 5611,
  parameter int unsigned StepUp    = 8,
  parameter int unsigned StepDown  = 32,
  parameter int unsigned DutyMax   = 4095,
  parameter int unsigned WdogTicks = 1000
) (
  input  logic        PWMClock,
  input  logic        Reset_n,
  input  logic [11:0] cmd_i,
  input  logic        cmd_valid_i,
  input  logic        enable_in_i,
  input  logic        brake_i,
  input  logic        fault_clr_i,
  output logic [11:0] duty_out_o,
  output logic        motor_enable_o,
  output logic        at_target_o,
  output logic        fault_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRamp  = 3'd1,
    StRun   = 3'd2,
    StBrake = 3'd3,
    StFault = 3'd4
  } state_e;

  localparam int unsigned WdogW     = $clog2(WdogTicks + 1);
  localparam logic [12:0] DutyMaxW  = 13'(DutyMax);
  localparam logic [11:0] DutyMax12 = 12'(DutyMax);
  localparam logic [12:0] StepUpW   = 13'(StepUp);
  localparam logic [12:0] StepDownW = 13'(StepDown);
  localparam logic [12:0] TickLast  = 13'(TickDiv - 1);
  localparam logic [WdogW-1:0] WdogLimit = WdogW'(WdogTicks);

  state_e           state_q, state_d;
  logic [11:0]      duty_q, duty_d;
  logic [11:0]      target_q, target_d;
  logic [12:0]      cnt_q, cnt_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             motor_en_q, motor_en_d;
  logic             at_target_q, at_target_d;
  logic             fault_q, fault_d;

  logic             tick;
  logic             wdog_expired;
  logic [11:0]      eff_target;
  logic [12:0]      duty_w, eff_w, diff, step_sum;
  logic [11:0]      stepped;

  assign tick         = (cnt_q == TickLast);
  assign wdog_expired = (wdog_q >= WdogLimit);
  assign eff_target   = (!enable_in_i || state_q == StFault) ? 12'd0 : target_q;

  // One slew-limited step toward the effective target, computed in 13 bits so nothing wraps.
  always_comb begin
    duty_w = {1'b0, duty_q};
    eff_w  = {1'b0, eff_target};
    diff   = '0;
    if (duty_w < eff_w) begin
      diff     = eff_w - duty_w;
      step_sum = duty_w + ((diff < StepUpW) ? diff : StepUpW);
    end else begin
      diff     = duty_w - eff_w;
      step_sum = duty_w - ((diff < StepDownW) ? diff : StepDownW);
    end
    stepped = (step_sum > DutyMaxW) ? DutyMax12 : step_sum[11:0];
  end

  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    cnt_d       = tick ? 13'd0 : cnt_q + 13'd1;
    target_d    = target_q;
    wdog_d      = wdog_q;
    at_target_d = (duty_q == eff_target);

    if (cmd_valid_i) begin
      target_d = ({1'b0, cmd_i} > DutyMaxW) ? DutyMax12 : cmd_i;
    end

    unique case (state_q)
      StIdle: begin
        duty_d = 12'd0;
        if (eff_target != 12'd0) state_d = StRamp;
      end
      StRamp: begin
        if (tick) duty_d = stepped;
        if (wdog_expired) begin
          state_d = StFault;
        end else if (eff_target != 12'd0 && duty_q == eff_target) begin
          state_d = StRun;
        end else if (eff_target == 12'd0 && duty_q == 12'd0) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (wdog_expired) begin
          state_d = StFault;
        end else if (duty_q != eff_target) begin
          state_d = StRamp;
        end
      end
      StBrake: begin
        duty_d = 12'd0;
        if (target_q == 12'd0) state_d = StIdle;
      end
      StFault: begin
        if (tick) duty_d = stepped;
        if (brake_i) duty_d = 12'd0;
        if (duty_q == 12'd0 && fault_clr_i) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        duty_d  = 12'd0;
      end
    endcase

    // Brake outranks the watchdog everywhere except FAULT, which only loses its duty.
    if (brake_i && state_q != StFault) begin
      state_d = StBrake;
      duty_d  = 12'd0;
    end

    if (cmd_valid_i || brake_i || state_q == StIdle || state_q == StBrake) begin
      wdog_d = '0;
    end else if (tick && (state_q == StRamp || state_q == StRun) && !wdog_expired) begin
      wdog_d = wdog_q + WdogW'(1);
    end

    fault_d = (state_d == StFault);
    unique case (state_d)
      StRamp, StRun: motor_en_d = 1'b1;
      StFault:       motor_en_d = (duty_d != 12'd0);
      default:       motor_en_d = 1'b0;
    endcase
  end

  always_ff @(posedge PWMClock) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      duty_q      <= 12'd0;
      target_q    <= 12'd0;
      cnt_q       <= 13'd0;
      wdog_q      <= '0;
      motor_en_q  <= 1'b0;
      at_target_q <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      wdog_q      <= wdog_d;
      motor_en_q  <= motor_en_d;
      at_target_q <= at_target_d;
      fault_q     <= fault_d;
    end
  end

  assign duty_out_o     = duty_q;
  assign motor_enable_o = motor_en_q;
  assign at_target_o    = at_target_q;
  assign fault_o        = fault_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_motor_duty_sequencer.sv
// Bench for motor_duty_sequencer: directed scenarios plus random traffic, each cycle compared
// against a rule-level reference model.
module tb_motor_duty_sequencer;

  localparam int TD   = 4;
  localparam int SU   = 8;
  localparam int SD   = 32;
  localparam int DMAX = 4095;
  localparam int WD   = 12;

  localparam int S_IDLE  = 0;
  localparam int S_RAMP  = 1;
  localparam int S_RUN   = 2;
  localparam int S_BRAKE = 3;
  localparam int S_FAULT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] cmd = '0;
  logic        cmd_valid = 1'b0;
  logic        en_in = 1'b0;
  logic        brake = 1'b0;
  logic        fault_clr = 1'b0;
  logic [11:0] duty;
  logic        motor_en;
  logic        at_tgt;
  logic        fault;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  // Reference model state (plain integers, updated from the rules each clock)
  int m_state = S_IDLE, m_duty = 0, m_tgt = 0, m_cnt = 0, m_wd = 0;
  int m_en = 0, m_at = 1, m_fault = 0;

  // Observation bookkeeping for directed checks
  int seen_v[$];
  int seen_t[$];
  int last_duty = 0;
  int max_up = 0;
  int ramp_en_bad = 0;

  motor_duty_sequencer #(
    .TickDiv  (TD),
    .StepUp   (SU),
    .StepDown (SD),
    .DutyMax  (DMAX),
    .WdogTicks(WD)
  ) dut (
    .PWMClock      (clk),
    .Reset_n       (rst_n),
    .cmd_i         (cmd),
    .cmd_valid_i   (cmd_valid),
    .enable_in_i   (en_in),
    .brake_i       (brake),
    .fault_clr_i   (fault_clr),
    .duty_out_o    (duty),
    .motor_enable_o(motor_en),
    .at_target_o   (at_tgt),
    .fault_o       (fault),
    .state_o       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed timeout expected event", tag);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Advance one clock, update the model from the pre-edge inputs, then compare all outputs.
  task automatic cyc();
    int tick, eff, nst, nduty, toward;
    @(posedge clk);
    cycle_no++;
    if (!rst_n) begin
      m_state = S_IDLE; m_duty = 0; m_tgt = 0; m_cnt = 0; m_wd = 0;
      m_en = 0; m_at = 1; m_fault = 0;
    end else begin
      tick = (m_cnt == TD - 1);
      eff  = (en_in && m_state != S_FAULT) ? m_tgt : 0;
      if (m_duty < eff) toward = m_duty + imin(SU, eff - m_duty);
      else              toward = m_duty - imin(SD, m_duty - eff);
      if (toward > DMAX) toward = DMAX;
      nst = m_state;
      nduty = m_duty;
      if (brake && m_state != S_FAULT) begin
        nst = S_BRAKE;
        nduty = 0;
      end else begin
        case (m_state)
          S_IDLE: begin
            nduty = 0;
            if (eff > 0) nst = S_RAMP;
          end
          S_RAMP: begin
            if (tick) nduty = toward;
            if (m_wd >= WD) nst = S_FAULT;
            else if (eff > 0 && m_duty == eff) nst = S_RUN;
            else if (eff == 0 && m_duty == 0) nst = S_IDLE;
          end
          S_RUN: begin
            if (m_wd >= WD) nst = S_FAULT;
            else if (m_duty != eff) nst = S_RAMP;
          end
          S_BRAKE: begin
            nduty = 0;
            if (m_tgt == 0) nst = S_IDLE;
          end
          default: begin
            if (tick) nduty = toward;
            if (brake) nduty = 0;
            if (m_duty == 0 && fault_clr) nst = S_IDLE;
          end
        endcase
      end
      if (cmd_valid || brake || m_state == S_IDLE || m_state == S_BRAKE) m_wd = 0;
      else if (tick && (m_state == S_RAMP || m_state == S_RUN) && m_wd < WD) m_wd++;
      m_at    = (m_duty == eff) ? 1 : 0;
      m_cnt   = (m_cnt + 1) % TD;
      if (cmd_valid) m_tgt = imin(int'(cmd), DMAX);
      m_state = nst;
      m_duty  = nduty;
      m_en    = (nst == S_RAMP || nst == S_RUN || (nst == S_FAULT && nduty > 0)) ? 1 : 0;
      m_fault = (nst == S_FAULT) ? 1 : 0;
    end
    #1;
    chk("duty_out", 32'(duty), m_duty);
    chk("motor_enable", 32'(motor_en), m_en);
    chk("at_target", 32'(at_tgt), m_at);
    chk("fault", 32'(fault), m_fault);
    chk("state", 32'(state), m_state);
    if (int'(duty) != last_duty) begin
      seen_v.push_back(int'(duty));
      seen_t.push_back(cycle_no);
      if (int'(duty) > last_duty && int'(duty) - last_duty > max_up) max_up = int'(duty) - last_duty;
      last_duty = int'(duty);
    end
    if (state == 3'd1 && !motor_en) ramp_en_bad++;
  endtask

  task automatic run(input int n, input bit keepalive);
    for (int i = 0; i < n; i++) begin
      cmd_valid = keepalive && (i % 8 == 0);
      cyc();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic strobe(input int v);
    cmd = 12'(v);
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) until the model reaches a duty (which=0) or state (which=1) value.
  task automatic wait_for(input string tag, input int which, input int val, input int limit,
                          input bit keepalive);
    int n = 0;
    while (((which == 0) ? m_duty : m_state) != val && n < limit) begin
      cmd_valid = keepalive && (n % 8 == 0);
      cyc();
      cmd_valid = 1'b0;
      n++;
    end
    if (((which == 0) ? m_duty : m_state) != val) timeout(tag);
  endtask

  task automatic chk_seen(input string tag, input int e0, input int e1, input int e2,
                          input int e3, input int e4, input int len);
    int exp_v[5];
    exp_v = '{e0, e1, e2, e3, e4};
    chk({tag, "_len"}, seen_v.size(), len);
    for (int i = 0; i < len && i < seen_v.size(); i++) chk(tag, seen_v[i], exp_v[i]);
  endtask

  function automatic void clear_seen();
    seen_v.delete();
    seen_t.delete();
  endfunction

  initial begin
    int d0;
    // Reset state
    run(3, 1'b0);
    chk("rst_duty", 32'(duty), 0);
    chk("rst_en", 32'(motor_en), 0);
    chk("rst_at", 32'(at_tgt), 1);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_state", 32'(state), S_IDLE);
    rst_n = 1'b1;
    en_in = 1'b1;

    // Ramp-up 0 -> 40
    clear_seen();
    strobe(40);
    run(30, 1'b0);
    chk_seen("rampup", 8, 16, 24, 32, 40, 5);
    for (int i = 0; i + 1 < seen_t.size(); i++) chk("rampup_gap", seen_t[i+1] - seen_t[i], TD);
    chk("rampup_state", 32'(state), S_RUN);
    chk("rampup_at", 32'(at_tgt), 1);
    chk("rampup_en_held", ramp_en_bad, 0);

    // Ramp-down with clipped last step, then back to idle
    strobe(100);
    run(60, 1'b1);
    chk("at100_duty", 32'(duty), 100);
    clear_seen();
    strobe(10);
    run(30, 1'b1);
    chk_seen("rampdn", 68, 36, 10, 0, 0, 3);
    chk("rampdn_state", 32'(state), S_RUN);
    strobe(0);
    run(20, 1'b1);
    chk("zero_duty", 32'(duty), 0);
    chk("zero_state", 32'(state), S_IDLE);
    chk("zero_en", 32'(motor_en), 0);

    // Brake mid-ramp, release only once the throttle is back at zero
    strobe(40);
    wait_for("brake_wait24", 0, 24, 100, 1'b0);
    brake = 1'b1;
    cyc();
    brake = 1'b0;
    chk("brake_duty", 32'(duty), 0);
    chk("brake_en", 32'(motor_en), 0);
    chk("brake_state", 32'(state), S_BRAKE);
    run(10, 1'b0);
    chk("brake_hold", 32'(state), S_BRAKE);
    strobe(0);
    run(2, 1'b0);
    chk("brake_exit", 32'(state), S_IDLE);

    // Watchdog expiry and fault clear
    strobe(64);
    wait_for("wd_run", 1, S_RUN, 200, 1'b1);
    chk("wd_duty64", 32'(duty), 64);
    wait_for("wd_fault", 1, S_FAULT, 200, 1'b0);
    chk("wd_fault_flag", 32'(fault), 1);
    clear_seen();
    wait_for("wd_32", 0, 32, 20, 1'b0);
    chk("wd_en_at32", 32'(motor_en), 1);
    fault_clr = 1'b1;
    cyc();
    fault_clr = 1'b0;
    chk("wd_clr_ignored", 32'(state), S_FAULT);
    chk("wd_fault_kept", 32'(fault), 1);
    wait_for("wd_0", 0, 0, 20, 1'b0);
    chk_seen("wd_down", 32, 0, 0, 0, 0, 2);
    chk("wd_en_at0", 32'(motor_en), 0);
    fault_clr = 1'b1;
    cyc();
    fault_clr = 1'b0;
    chk("wd_clr_state", 32'(state), S_IDLE);
    chk("wd_clr_fault", 32'(fault), 0);
    strobe(0);
    run(5, 1'b0);

    // Full-scale command: slew never exceeds STEP_UP
    max_up = 0;
    strobe(4095);
    run(200, 1'b1);
    chk("sat_max_step", max_up, SU);
    // cmd_valid on a tick: the step still uses the old target
    for (int i = 0; i < 8 && m_cnt != TD - 1; i++) cyc();
    d0 = m_duty;
    strobe(100);
    chk("simul_old_tgt", 32'(duty), d0 + SU);
    run(TD, 1'b0);
    chk("simul_new_tgt", 32'(duty), d0 + SU - SD);

    // Reset mid-operation
    strobe(200);
    wait_for("rst_wait200", 0, 200, 300, 1'b1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_duty", 32'(duty), 0);
    chk("mid_rst_en", 32'(motor_en), 0);
    chk("mid_rst_at", 32'(at_tgt), 1);
    chk("mid_rst_state", 32'(state), S_IDLE);

    // enable_in drop in RUN ramps down then idles
    strobe(96);
    wait_for("en_run", 1, S_RUN, 300, 1'b1);
    en_in = 1'b0;
    clear_seen();
    run(30, 1'b1);
    chk_seen("en_drop", 64, 32, 0, 0, 0, 3);
    chk("en_drop_state", 32'(state), S_IDLE);
    chk("en_drop_en", 32'(motor_en), 0);

    // Random traffic against the model
    en_in = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      cmd       = ($urandom % 4 == 0) ? 12'($urandom % 4096) : 12'($urandom % 200);
      cmd_valid = ($urandom % 6 == 0);
      brake     = ($urandom % 25 == 0);
      en_in     = ($urandom % 12 != 0);
      fault_clr = ($urandom % 8 == 0);
      rst_n     = ($urandom % 400 != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
